// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: parity modes, receiver FSM states and
// the sizing rule for the per-bit cycle counter.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // Bits needed to count 0 .. CLK_HZ/BIT_RATE-1.
    function automatic int cycle_cnt_width(input int clk_hz, input int bit_rate);
        int w;
        w = $clog2(clk_hz / bit_rate);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_rx_sfifo.sv
// Generic synchronous FIFO; DEPTH must be a power of two so the pointers
// wrap naturally. A pop on a full FIFO makes room for a same-cycle push.
module uart_rx_sfifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign empty   = (level == '0);
    assign full    = (level == (AW + 1)'(DEPTH));
    assign rdata   = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; pointers and level alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with start-bit validation, parity/framing/break detection and
// a receive FIFO. Define UART_RX_TIMEOUT_EN to enable the idle-gap pulse.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 48000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rxd,
    input  logic                          uart_rx_en,
    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [PAYLOAD_BITS-1:0]       rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          uart_rx_break,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    output logic                          uart_rx_idle
);
    localparam int            CPB       = CLK_HZ / BIT_RATE;
    localparam int            CW        = cycle_cnt_width(CLK_HZ, BIT_RATE);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
    localparam logic [3:0]    DATA_LAST = 4'(PAYLOAD_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    rx_state_t               state;
    logic [CW-1:0]           cycle_cnt;
    logic [3:0]              bit_cnt;
    logic [PAYLOAD_BITS-1:0] shreg;
    logic                    par_bit;
    logic                    stop_low;
    logic                    frame_done;
    logic                    rxd_meta, line, line_prev, line_fall;
    logic                    fifo_full, fifo_empty, pop, push;
    logic                    payload_zero, par_bad, word_ok;

    // Synchroniser flops reset to the idle-high level so reset never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta  <= 1'b1;
            line      <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            rxd_meta  <= uart_rxd;
            line      <= rxd_meta;
            line_prev <= line;
        end
    end

    assign line_fall = line_prev && !line;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cycle_cnt  <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            stop_low   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!uart_rx_en) begin
                state     <= ST_IDLE;
                cycle_cnt <= '0;
                bit_cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (line_fall) begin
                            state     <= ST_START;
                            cycle_cnt <= '0;
                        end
                    end
                    ST_START: begin
                        if (cycle_cnt == HALF_LAST) begin
                            cycle_cnt <= '0;
                            bit_cnt   <= '0;
                            state     <= line ? ST_IDLE : ST_DATA;
                        end else cycle_cnt <= cycle_cnt + 1'b1;
                    end
                    ST_DATA: begin
                        if (cycle_cnt == BIT_LAST) begin
                            cycle_cnt <= '0;
                            shreg     <= {line, shreg[PAYLOAD_BITS-1:1]};
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt  <= '0;
                                stop_low <= 1'b0;
                                state    <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                            end else bit_cnt <= bit_cnt + 1'b1;
                        end else cycle_cnt <= cycle_cnt + 1'b1;
                    end
                    ST_PARITY: begin
                        if (cycle_cnt == BIT_LAST) begin
                            cycle_cnt <= '0;
                            par_bit   <= line;
                            state     <= ST_STOP;
                        end else cycle_cnt <= cycle_cnt + 1'b1;
                    end
                    ST_STOP: begin
                        if (cycle_cnt == BIT_LAST) begin
                            cycle_cnt <= '0;
                            stop_low  <= stop_low || !line;
                            if (bit_cnt == STOP_LAST) begin
                                bit_cnt    <= '0;
                                frame_done <= 1'b1;
                                state      <= ST_IDLE;
                            end else bit_cnt <= bit_cnt + 1'b1;
                        end else cycle_cnt <= cycle_cnt + 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Completion outcome: break, framing, parity, overflow, push -- first match wins.
    assign payload_zero = (shreg == '0);
    assign par_bad      = (PARITY != PAR_NONE) &&
                          (par_bit != ((PARITY == PAR_EVEN) ? ^shreg : ~^shreg));
    assign word_ok      = frame_done && !stop_low && !par_bad;
    assign pop          = rd_en && rd_valid;
    assign push         = word_ok && (!fifo_full || pop);
    assign rd_valid     = !fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uart_rx_break <= 1'b0;
            frame_err     <= 1'b0;
            parity_err    <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            uart_rx_break <= frame_done && stop_low && payload_zero;
            frame_err     <= frame_done && stop_low && !payload_zero;
            parity_err    <= frame_done && !stop_low && par_bad;
            overflow      <= word_ok && fifo_full && !pop;
        end
    end

    uart_rx_sfifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (shreg),
        .rdata (rd_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

`ifdef UART_RX_TIMEOUT_EN
    logic [CW-1:0] idle_cyc;
    logic [15:0]   idle_bits;
    logic          idle_fired;
    logic          idle_clr;
    logic          idle_run;

    assign idle_clr = ((state == ST_IDLE) && line_fall) || pop || !uart_rx_en;
    assign idle_run = (state == ST_IDLE) && line && !fifo_empty;

    // Counts whole bit periods of idle line with data waiting; fires once per gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cyc     <= '0;
            idle_bits    <= '0;
            idle_fired   <= 1'b0;
            uart_rx_idle <= 1'b0;
        end else begin
            uart_rx_idle <= 1'b0;
            if (idle_clr) begin
                idle_cyc   <= '0;
                idle_bits  <= '0;
                idle_fired <= 1'b0;
            end else if (idle_run) begin
                if (idle_cyc == BIT_LAST) begin
                    idle_cyc <= '0;
                    if (idle_bits != '1) idle_bits <= idle_bits + 1'b1;
                end else idle_cyc <= idle_cyc + 1'b1;
                if (idle_bits == 16'd4 && !idle_fired) begin
                    uart_rx_idle <= 1'b1;
                    idle_fired   <= 1'b1;
                end
            end
        end
    end
`else
    assign uart_rx_idle = 1'b0;
`endif

endmodule
